// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the req/gnt/rvalid data-memory handshake, formats loads and stores, and owns the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module mem_stage #(
  parameter int RSP_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        reg_write_en_in,
  input  logic [1:0]  mem_to_reg_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] load_data_out,
  output logic [4:0]  rd_addr_out,
  output logic        reg_write_en_out,
  output logic [1:0]  mem_to_reg_out,
  output logic        bus_timeout_out,
  output logic        misalign_exc_out
);

  localparam int CW      = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam int TO_LAST = (RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic        mem_op;
  logic        is_store;
  logic        trap;
  logic        timeout_hit;
  logic        req;
  logic        done;
  logic        abort;
  logic        to_rsp;
  logic        to_gnt;
  logic        finish;
  logic        pass_thru;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;
  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;

  assign mem_op   = valid_in & (mem_read_en_in | mem_write_en_in);
  assign is_store = mem_write_en_in;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((funct3_in[1:0] == 2'b01) & alu_result_in[0]) |
                      ((funct3_in[1:0] == 2'b10) & (alu_result_in[1:0] != 2'b00));
  assign trap = (state == IDLE) & mem_op & misaligned;
`else
  assign trap = 1'b0;
`endif

  // The counter value is the number of wait cycles already spent before this one.
  assign timeout_hit = (RSP_TIMEOUT != 0) && (wait_cnt == CW'(TO_LAST));

  always_comb begin
    req    = 1'b0;
    done   = 1'b0;
    abort  = 1'b0;
    to_rsp = 1'b0;
    to_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !trap) begin
          req = 1'b1;
          if (!dmem_gnt)    to_gnt = 1'b1;
          else if (is_store) done  = 1'b1;
          else               to_rsp = 1'b1;
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (is_store) done   = 1'b1;
          else          to_rsp = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid)      done  = 1'b1;
        else if (timeout_hit) abort = 1'b1;
      end
      default: ;
    endcase
  end

  assign finish    = done | abort | trap;
  assign pass_thru = (state == IDLE) & valid_in & ~mem_op;

  // Reset gates the combinational outputs so the bus drops the same cycle rst rises.
  assign stall_out  = ~rst & ((state != IDLE) | mem_op) & ~finish;
  assign dmem_req   = ~rst & req;
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = dmem_req ? {alu_result_in[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = dmem_req ? wdata_fmt : 32'h0;
  assign dmem_be    = dmem_req ? be_fmt : 4'b0000;

  // Sub-word stores are lane-replicated; half-word lanes ignore addr[0].
  always_comb begin
    wdata_fmt = store_data_in;
    be_fmt    = 4'b0000;
    case (funct3_in[1:0])
      2'b00: begin
        wdata_fmt = {4{store_data_in[7:0]}};
        be_fmt    = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{store_data_in[15:0]}};
        be_fmt    = 4'b0011 << {alu_result_in[1], 1'b0};
      end
      2'b10: be_fmt = 4'b1111;
      default: ;
    endcase
  end

  assign lane_byte = dmem_rdata[{alu_result_in[1:0], 3'b000} +: 8];
  assign lane_half = dmem_rdata[{alu_result_in[1], 4'b0000} +: 16];

  always_comb begin
    load_fmt = 32'h0;
    case (funct3_in)
      3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_fmt = {24'h0, lane_byte};
      3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_fmt = {16'h0, lane_half};
      3'b010:  load_fmt = dmem_rdata;
      default: load_fmt = 32'h0;
    endcase
  end

  // FSM and MEM/WB register; the register only loads when an instruction leaves the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      valid_out        <= 1'b0;
      alu_result_out   <= 32'h0;
      load_data_out    <= 32'h0;
      rd_addr_out      <= 5'h0;
      reg_write_en_out <= 1'b0;
      mem_to_reg_out   <= 2'b00;
      bus_timeout_out  <= 1'b0;
      misalign_exc_out <= 1'b0;
    end else begin
      if (finish) begin
        state    <= IDLE;
        wait_cnt <= '0;
      end else if (to_rsp) begin
        state    <= WAIT_RSP;
        wait_cnt <= '0;
      end else if (to_gnt) begin
        state    <= WAIT_GNT;
        wait_cnt <= '0;
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      valid_out        <= finish | pass_thru;
      bus_timeout_out  <= abort;
      misalign_exc_out <= trap;
      if (finish | pass_thru) begin
        alu_result_out   <= alu_result_in;
        rd_addr_out      <= rd_addr_in;
        mem_to_reg_out   <= mem_to_reg_in;
        reg_write_en_out <= reg_write_en_in & ~abort & ~trap;
        load_data_out    <= (done & ~is_store) ? load_fmt : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized instructions and bus timing against a behavioural model.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int TO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_MODE = 1'b1;
`else
  localparam bit TRAP_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_addr_in;
  logic        reg_write_en_in;
  logic [1:0]  mem_to_reg_in;
  logic [2:0]  funct3_in;
  logic        mem_read_en_in;
  logic        mem_write_en_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [31:0] alu_result_out;
  logic [31:0] load_data_out;
  logic [4:0]  rd_addr_out;
  logic        reg_write_en_out;
  logic [1:0]  mem_to_reg_out;
  logic        bus_timeout_out;
  logic        misalign_exc_out;

  mem_stage #(.RSP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .rd_addr_in(rd_addr_in), .reg_write_en_in(reg_write_en_in),
    .mem_to_reg_in(mem_to_reg_in), .funct3_in(funct3_in), .mem_read_en_in(mem_read_en_in),
    .mem_write_en_in(mem_write_en_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .alu_result_out(alu_result_out), .load_data_out(load_data_out),
    .rd_addr_out(rd_addr_out), .reg_write_en_out(reg_write_en_out),
    .mem_to_reg_out(mem_to_reg_out), .bus_timeout_out(bus_timeout_out),
    .misalign_exc_out(misalign_exc_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  m2r;
    logic        to;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 1;
    return TRAP_MODE && ((a % size) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      3'd2:    return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bus_t ref_bus(input bit store, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bus_t r;
    r.we    = store;
    r.addr  = a & 32'hFFFFFFFC;
    r.wdata = d;
    r.be    = 4'b1111;
    if (f3[1:0] == 2'd0) begin
      r.wdata = d[7:0] * 32'h01010101;
      r.be    = 4'(1 << a[1:0]);
    end else if (f3[1:0] == 2'd1) begin
      r.wdata = d[15:0] * 32'h00010001;
      r.be    = a[1] ? 4'b1100 : 4'b0011;
    end
    return r;
  endfunction

  // kind: 0 non-memory, 1 load, 2 store. drop: 0 none, 1 never grant, 2 never respond.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] rdata, input logic [4:0] rd,
                               input logic rwe, input logic [1:0] m2r, input int gd, input int rdl,
                               input int drop);
    exp_t e;
    bit   trapped;
    bit   aborted;
    int   exp_stall;
    int   stalls;
    int   c;
    trapped   = (kind != 0) && is_misaligned(f3, a);
    aborted   = 1'b0;
    exp_stall = 0;
    if (kind != 0 && !trapped) begin
      if (drop == 1) begin
        aborted   = 1'b1;
        exp_stall = TO;
      end else if (kind == 2) begin
        exp_stall = gd;
      end else if (drop == 2) begin
        aborted   = 1'b1;
        exp_stall = gd + TO;
      end else begin
        exp_stall = gd + 1 + rdl;
      end
      bus_q.push_back(ref_bus(kind == 2, f3, a, sd));
    end
    e.alu = a;
    e.ld  = (kind == 1 && !trapped && !aborted) ? ref_load(f3, a, rdata) : 32'h0;
    e.rd  = rd;
    e.we  = rwe && !trapped && !aborted;
    e.m2r = m2r;
    e.to  = aborted;
    e.mis = trapped;
    exp_q.push_back(e);

    valid_in = 1'b1; alu_result_in = a; store_data_in = sd; rd_addr_in = rd;
    reg_write_en_in = rwe; mem_to_reg_in = m2r; funct3_in = f3; dmem_rdata = rdata;
    mem_read_en_in = (kind == 1); mem_write_en_in = (kind == 2);
    stalls = 0;
    c      = 0;
    forever begin
      dmem_gnt    = (kind != 0) && (drop != 1) && (c == gd);
      dmem_rvalid = (kind == 1) && (drop == 0) && (c == gd + 1 + rdl);
      @(negedge clk);
      if (c == 0) checkOutput("dmem_req_first", dmem_req, (kind != 0) && !trapped);
      if (!stall_out) break;
      stalls++;
      if (c >= 60) begin
        checkOutput("cycle_bound", stall_out, 0);
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    checkOutput("stall_cycles", stalls, exp_stall);
    @(posedge clk); #1;
    if (drop == 1 && kind != 0 && !trapped && bus_q.size() > 0) void'(bus_q.pop_back());
    valid_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
  endtask

  // Bubble cycle, optionally with a stray gnt/rvalid that must be ignored.
  task automatic idleCycle(input bit stray);
    valid_in = 1'b0; mem_read_en_in = 1'($urandom); mem_write_en_in = 1'($urandom);
    dmem_gnt = stray; dmem_rvalid = stray; dmem_rdata = $urandom;
    @(negedge clk);
    checkOutput("idle_stall", stall_out, 0);
    checkOutput("idle_req", dmem_req, 0);
    @(posedge clk); #1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
  endtask

  // Write-back monitor: every valid_out must match the oldest expected completion.
  always @(negedge clk) begin : wb_monitor
    exp_t e;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid_out", valid_out, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("alu_result_out", alu_result_out, e.alu);
        checkOutput("load_data_out", load_data_out, e.ld);
        checkOutput("rd_addr_out", rd_addr_out, e.rd);
        checkOutput("reg_write_en_out", reg_write_en_out, e.we);
        checkOutput("mem_to_reg_out", mem_to_reg_out, e.m2r);
        checkOutput("bus_timeout_out", bus_timeout_out, e.to);
        checkOutput("misalign_exc_out", misalign_exc_out, e.mis);
      end
    end
  end

  // Bus monitor: a live request must match the oldest pending access every cycle until granted.
  always @(negedge clk) begin : bus_monitor
    bus_t b;
    if (dmem_req) begin
      if (bus_q.size() == 0) begin
        checkOutput("unexpected_req", dmem_req, 0);
      end else begin
        b = bus_q[0];
        checkOutput("dmem_we", dmem_we, b.we);
        checkOutput("dmem_addr", dmem_addr, b.addr);
        if (b.we) begin
          checkOutput("dmem_wdata", dmem_wdata, b.wdata);
          checkOutput("dmem_be", dmem_be, b.be);
        end
        if (dmem_gnt) void'(bus_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int kind;
    int drop;
    logic [2:0] f3;
    rst = 1'b1; valid_in = 1'b1; mem_read_en_in = 1'b0; mem_write_en_in = 1'b1;
    alu_result_in = 32'h104; store_data_in = 32'hFFFFFFFF; rd_addr_in = 5'd3;
    reg_write_en_in = 1'b1; mem_to_reg_in = 2'b01; funct3_in = 3'd2;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    checkOutput("reset_stall", stall_out, 0);
    checkOutput("reset_req", dmem_req, 0);
    checkOutput("reset_addr", dmem_addr, 0);
    checkOutput("reset_be", dmem_be, 0);
    checkOutput("reset_valid_out", valid_out, 0);
    checkOutput("reset_load_data", load_data_out, 0);
    @(posedge clk); #1;
    valid_in = 1'b0; mem_write_en_in = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 5'd1, 1'b1, 2'b01, 0, 0, 0);
    applyStimulus(1, 3'd0, 32'h103, 32'h0, 32'h80FFFF7F, 5'd2, 1'b1, 2'b01, 0, 1, 0);
    applyStimulus(1, 3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 5'd3, 1'b1, 2'b01, 1, 0, 0);
    applyStimulus(1, 3'd5, 32'h102, 32'h0, 32'h80FFFF7F, 5'd4, 1'b1, 2'b01, 0, 0, 0);
    applyStimulus(2, 3'd0, 32'h101, 32'h12345678, 32'h0, 5'd0, 1'b0, 2'b00, 0, 0, 0);
    applyStimulus(2, 3'd2, 32'h200, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0, 2'b00, 3, 0, 0);
    applyStimulus(0, 3'd0, 32'h55AA55AA, 32'h0, 32'h0, 5'd7, 1'b1, 2'b00, 0, 0, 0);
    applyStimulus(1, 3'd2, 32'h300, 32'h0, 32'h11111111, 5'd8, 1'b1, 2'b01, 0, 0, 2);
    idleCycle(1'b1);
    applyStimulus(2, 3'd1, 32'h402, 32'hABCD1234, 32'h0, 5'd0, 1'b0, 2'b00, 0, 0, 1);
    applyStimulus(1, 3'd2, 32'h102, 32'h0, 32'h01234567, 5'd9, 1'b1, 2'b01, 0, 0, 0);
    applyStimulus(1, 3'd2, 32'h104, 32'h0, 32'h89ABCDEF, 5'd10, 1'b1, 2'b01, TO, TO - 1, 0);

    // Reset while waiting for read data must drop everything immediately.
    bus_q.push_back(ref_bus(1'b0, 3'd2, 32'h200, 32'h0));
    valid_in = 1'b1; mem_read_en_in = 1'b1; mem_write_en_in = 1'b0; funct3_in = 3'd2;
    alu_result_in = 32'h200; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("wait_rsp_stall", stall_out, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_stall", stall_out, 0);
    checkOutput("midrst_req", dmem_req, 0);
    checkOutput("midrst_valid_out", valid_out, 0);
    checkOutput("midrst_load_data", load_data_out, 0);
    checkOutput("midrst_alu_result", alu_result_out, 0);
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read_en_in = 1'b0; rst = 1'b0;
    idleCycle(1'b1);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else           f3 = 3'($urandom);
      applyStimulus(kind, f3, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                    2'($urandom), $urandom_range(0, TO), $urandom_range(0, TO - 1), drop);
      if ($urandom_range(0, 5) == 0) idleCycle(1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("exp_q_drained", exp_q.size(), 0);
    checkOutput("bus_q_drained", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
